// File: rtl/keccak_msg_feeder_pkg.sv
// Shared definitions for the keccak message feeder.
// Widths of the byte stream, the core input word and the core digest, and the
// feeder state encoding.
package keccak_feed_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DIGEST_W = 512;
    localparam int unsigned CNT_W    = 3;   // holds 0..4 bytes per word

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        COLLECT = 3'd2,
        SEND    = 3'd3,
        PAD     = 3'd4,
        WAIT    = 3'd5
    } feed_state_t;

endpackage

// File: rtl/keccak_msg_feeder_byte_packer.sv
// Big-endian byte packer for the keccak feeder.
// Ports:
//   clk, i_rst_n     : clock and synchronous active-low reset
//   i_clear          : empty the word (count=0, word=0, last=0)
//   i_load, i_byte   : insert i_byte at the current byte position
//   i_last           : last-byte marker captured with the load
//   o_word_nxt       : word as it will be after loading i_byte now
//   o_count_nxt      : byte count after loading i_byte now
//   o_full           : four bytes held
//   o_last           : the most recent loaded byte carried the last marker
module keccak_byte_packer
    import keccak_feed_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_word_nxt,
    output logic [CNT_W-1:0]  o_count_nxt,
    output logic              o_full,
    output logic              o_last
);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;
    logic              r_last;
    logic [WORD_W-1:0] w_word_nxt;

    // Byte k lands in bits [31-8k -: 8]; untouched lanes stay zero from clear.
    always_comb begin
        w_word_nxt = r_word;
        case (r_count[1:0])
            2'd0:    w_word_nxt[31:24] = i_byte;
            2'd1:    w_word_nxt[23:16] = i_byte;
            2'd2:    w_word_nxt[15:8]  = i_byte;
            default: w_word_nxt[7:0]   = i_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_word  <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_word  <= w_word_nxt;
            r_count <= r_count + 1'b1;
            r_last  <= i_last;
        end
    end

    assign o_word_nxt  = w_word_nxt;
    assign o_count_nxt = r_count + 1'b1;
    assign o_full      = (r_count == 3'd4);
    assign o_last      = r_last;

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for the keccak core.
// Packs valid/ready bytes into 32-bit big-endian words for the core's
// in/in_ready/is_last/byte_num interface, pulses the core reset before each
// message, adds a zero pad word when the message is a multiple of 4 bytes,
// then waits (bounded by WAIT_LIMIT cycles) for out_ready.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   s_data/s_valid/s_last : byte source, s_ready accepts
//   core_*                : keccak input side, core_buffer_full stalls,
//                           core_out_ready ends the message
//   busy, done, err       : message in progress, completion pulse, timeout flag
module keccak_msg_feeder
    import keccak_feed_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              core_reset,
    output logic [WORD_W-1:0] core_in,
    output logic              core_in_ready,
    output logic              core_is_last,
    output logic [1:0]        core_byte_num,
    input  logic              core_buffer_full,
    input  logic              core_out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMR_W = $clog2(WAIT_LIMIT + 1);

    feed_state_t       r_state;
    logic              r_s_ready;
    logic              r_core_reset;
    logic [WORD_W-1:0] r_core_in;
    logic              r_in_ready;
    logic              r_is_last;
    logic [1:0]        r_byte_num;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [TMR_W-1:0]  r_timer;

    logic              w_accept;
    logic              w_consume;
    logic              w_clear;
    logic [WORD_W-1:0] w_word_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_full;
    logic              w_last;
    logic              w_word_done;

    assign w_accept    = (r_state == COLLECT) && r_s_ready && s_valid;
    assign w_consume   = !core_buffer_full;
    assign w_word_done = (w_count_nxt == 3'd4) || s_last;
    // The word is emptied at CLR and whenever the core takes a data word.
    assign w_clear     = (r_state == CLR) || ((r_state == SEND) && w_consume);

    keccak_byte_packer u_packer (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_clear     (w_clear),
        .i_load      (w_accept),
        .i_byte      (s_data),
        .i_last      (s_last),
        .o_word_nxt  (w_word_nxt),
        .o_count_nxt (w_count_nxt),
        .o_full      (w_full),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_s_ready    <= 1'b0;
            r_core_reset <= 1'b1;
            r_core_in    <= '0;
            r_in_ready   <= 1'b0;
            r_is_last    <= 1'b0;
            r_byte_num   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_done       <= 1'b0;
            r_core_reset <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state      <= CLR;
                        r_busy       <= 1'b1;
                        r_err        <= 1'b0;
                        r_core_reset <= 1'b1;
                    end
                end
                CLR: begin
                    r_state   <= COLLECT;
                    r_s_ready <= 1'b1;
                end
                COLLECT: begin
                    // Core outputs are loaded from the packer's look-ahead word
                    // so they are valid on the first SEND cycle.
                    if (w_accept && w_word_done) begin
                        r_state    <= SEND;
                        r_s_ready  <= 1'b0;
                        r_core_in  <= w_word_nxt;
                        r_in_ready <= 1'b1;
                        if (s_last && (w_count_nxt != 3'd4)) begin
                            r_is_last  <= 1'b1;
                            r_byte_num <= w_count_nxt[1:0];
                        end
                    end
                end
                SEND: begin
                    if (w_consume) begin
                        r_core_in  <= '0;
                        r_byte_num <= '0;
                        if (!w_last) begin
                            r_state    <= COLLECT;
                            r_s_ready  <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_full) begin
                            // Full final word: follow with an empty is_last word.
                            r_state   <= PAD;
                            r_is_last <= 1'b1;
                        end else begin
                            r_state    <= WAIT;
                            r_in_ready <= 1'b0;
                            r_is_last  <= 1'b0;
                            r_timer    <= '0;
                        end
                    end
                end
                PAD: begin
                    if (w_consume) begin
                        r_state    <= WAIT;
                        r_in_ready <= 1'b0;
                        r_is_last  <= 1'b0;
                        r_timer    <= '0;
                    end
                end
                WAIT: begin
                    if (core_out_ready) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_timer == TMR_W'(WAIT_LIMIT - 1)) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready       = r_s_ready;
    assign core_reset    = r_core_reset;
    assign core_in       = r_core_in;
    assign core_in_ready = r_in_ready;
    assign core_is_last  = r_is_last;
    assign core_byte_num = r_byte_num;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed testbench for keccak_msg_feeder: byte source and core side are
// driven from one initial block; a posedge monitor records every word the
// core would take.
module tb_keccak_msg_feeder;

    localparam int unsigned WL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        core_reset;
    logic [31:0] core_in;
    logic        core_in_ready;
    logic        core_is_last;
    logic [1:0]  core_byte_num;
    logic        core_buffer_full;
    logic        core_out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    keccak_msg_feeder #(.WAIT_LIMIT(WL)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out_ready   (core_out_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Core-side monitor: a word is taken at a posedge with in_ready && !buffer_full.
    logic [31:0] mon_word [128];
    logic        mon_last [128];
    logic [1:0]  mon_bn   [128];
    int          mon_n  = 0;
    int          n_clr  = 0;
    int          n_done = 0;

    always @(posedge clk) begin
        if (reset && core_in_ready && !core_buffer_full && mon_n < 128) begin
            mon_word[mon_n] = core_in;
            mon_last[mon_n] = core_is_last;
            mon_bn[mon_n]   = core_byte_num;
            mon_n = mon_n + 1;
        end
        if (reset && core_reset && busy) n_clr = n_clr + 1;
        if (done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned guard = 0;
        s_data  = b;
        s_valid = 1'b1;
        s_last  = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            errors++;
            $error("FAIL s_ready_timeout: observed 0 expected 1");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_range(input string m, input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(m[i], (i == m.len() - 1));
    endtask

    task automatic send_msg(input string m);
        send_range(m, 0, m.len());
    endtask

    // Wait for the words to drain, respond with out_ready a few cycles later,
    // and check the done pulse.
    task automatic finish_msg(input int base, input int nw);
        int unsigned guard = 0;
        while (mon_n < base + nw && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        core_out_ready = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 20);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        core_out_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    function automatic logic [31:0] exp_word(input string m, input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (4 * w + k < m.len()) r[31 - 8 * k -: 8] = m[4 * w + k];
        return r;
    endfunction

    task automatic check_msg(input string m, input int base);
        int nw;
        nw = m.len() / 4 + 1;
        chk("word_count", 32'(mon_n - base), 32'(nw));
        for (int w = 0; w < nw; w++) begin
            if (base + w < mon_n) begin
                chk("word", mon_word[base + w], exp_word(m, w));
                chk("is_last", {31'b0, mon_last[base + w]}, (w == nw - 1) ? 32'd1 : 32'd0);
                chk("byte_num", {30'b0, mon_bn[base + w]},
                    (w == nw - 1) ? 32'(m.len() % 4) : 32'd0);
            end
        end
    endtask

    initial begin
        int base;
        int clr0;
        int done0;
        string fox;

        reset            = 1'b0;
        s_data           = '0;
        s_valid          = 1'b0;
        s_last           = 1'b0;
        core_buffer_full = 1'b0;
        core_out_ready   = 1'b0;
        fox = "The quick brown fox jumps over the lazy dog";

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_core_in", core_in, 32'd0);
        chk("rst_in_ready", {31'b0, core_in_ready}, 32'd0);
        chk("rst_is_last", {31'b0, core_is_last}, 32'd0);
        chk("rst_byte_num", {30'b0, core_byte_num}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_core_reset", {31'b0, core_reset}, 32'd0);

        // "Hello, world!" with a one-cycle core reset before the first word
        base  = mon_n;
        clr0  = n_clr;
        done0 = n_done;
        s_data  = "H";
        s_valid = 1'b1;
        @(negedge clk);
        chk("clr_core_reset", {31'b0, core_reset}, 32'd1);
        chk("clr_busy", {31'b0, busy}, 32'd1);
        chk("clr_s_ready", {31'b0, s_ready}, 32'd0);
        chk("clr_no_word_yet", 32'(mon_n - base), 32'd0);
        send_msg("Hello, world!");
        finish_msg(base, 4);
        chk("hello13_w0", mon_word[base], 32'h48656C6C);
        chk("hello13_w1", mon_word[base + 1], 32'h6F2C2077);
        chk("hello13_w2", mon_word[base + 2], 32'h6F726C64);
        chk("hello13_w3", mon_word[base + 3], 32'h21000000);
        chk("hello13_bn", {30'b0, mon_bn[base + 3]}, 32'd1);
        chk("hello13_clr", 32'(n_clr - clr0), 32'd1);
        chk("hello13_done", 32'(n_done - done0), 32'd1);
        check_msg("Hello, world!", base);

        // "Hello, world": multiple of 4 -> zero pad word
        base = mon_n;
        send_msg("Hello, world");
        finish_msg(base, 4);
        chk("hello12_pad", mon_word[base + 3], 32'h00000000);
        chk("hello12_pad_last", {31'b0, mon_last[base + 3]}, 32'd1);
        check_msg("Hello, world", base);

        // Fox with a 5-cycle buffer_full stall on the first word
        base = mon_n;
        core_buffer_full = 1'b1;
        send_range(fox, 0, 4);
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", {31'b0, core_in_ready}, 32'd1);
            chk("stall_core_in", core_in, 32'h54686520);
            chk("stall_no_take", 32'(mon_n - base), 32'd0);
            @(negedge clk);
        end
        core_buffer_full = 1'b0;
        send_range(fox, 4, fox.len());
        finish_msg(base, 11);
        chk("fox_last_word", mon_word[base + 10], 32'h646F6700);
        check_msg(fox, base);

        // Back-to-back messages, each with its own core reset pulse
        base = mon_n;
        clr0 = n_clr;
        send_msg("1234567890");
        finish_msg(base, 3);
        check_msg("1234567890", base);
        chk("b2b_clr1", 32'(n_clr - clr0), 32'd1);
        base = mon_n;
        send_msg("password123");
        finish_msg(base, 3);
        chk("pw_last_word", mon_word[base + 2], 32'h31323300);
        chk("pw_last_bn", {30'b0, mon_bn[base + 2]}, 32'd3);
        check_msg("password123", base);
        chk("b2b_clr2", 32'(n_clr - clr0), 32'd2);

        // WAIT timeout: err exactly WL cycles after entering WAIT
        done0 = n_done;
        send_msg("abc");
        repeat (WL) @(negedge clk);
        chk("to_err_early", {31'b0, err}, 32'd0);
        chk("to_busy_early", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_busy", {31'b0, busy}, 32'd0);
        chk("to_no_done", 32'(n_done - done0), 32'd0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", {31'b0, err}, 32'd1);
        base = mon_n;
        s_data  = "x";
        s_valid = 1'b1;
        @(negedge clk);
        chk("err_cleared", {31'b0, err}, 32'd0);
        send_msg("xy");
        finish_msg(base, 1);
        check_msg("xy", base);

        // Reset while stalled in SEND, then a clean message
        core_buffer_full = 1'b1;
        send_msg("wxyz");
        chk("pre_rst_in_ready", {31'b0, core_in_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'b0, core_in_ready}, 32'd0);
        chk("mid_rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("mid_rst_s_ready", {31'b0, s_ready}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_core_in", core_in, 32'd0);
        reset = 1'b1;
        core_buffer_full = 1'b0;
        @(negedge clk);
        chk("post_rst_core_reset", {31'b0, core_reset}, 32'd0);
        chk("post_rst_in_ready", {31'b0, core_in_ready}, 32'd0);
        base = mon_n;
        send_msg("Hello, world!");
        finish_msg(base, 4);
        check_msg("Hello, world!", base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
Front end for the keccak core. It accepts a byte stream with a valid/ready handshake and packs it into 32-bit words in the core's input format (in, in_ready, is_last, byte_num), honouring the core's buffer_full back-pressure. Before each message it pulses the core's active-high reset. After the last word it waits for out_ready, then reports completion. It sits between any byte-oriented message source and the keccak instance.

Parameters:
WAIT_LIMIT, 255, maximum cycles spent in WAIT for out_ready before err is raised (counter width = clog2(WAIT_LIMIT+1)).

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-low reset (reset==0 clears the block).
s_data  input  8  message byte.
s_valid  input  1  s_data valid.
s_last  input  1  marks the final byte of the message; qualified by s_valid.
s_ready  output  1  byte accepted on a cycle where s_valid&&s_ready.
core_reset  output  1  active-high reset to keccak.
core_in  output  32  word to keccak "in".
core_in_ready  output  1  to keccak in_ready.
core_is_last  output  1  to keccak is_last.
core_byte_num  output  2  to keccak byte_num.
core_buffer_full  input  1  from keccak buffer_full.
core_out_ready  input  1  from keccak out_ready.
busy  output  1  high from message start until done or err.
done  output  1  one-cycle pulse when core_out_ready is seen in WAIT.
err  output  1  sticky; set on WAIT timeout, cleared by reset or the next message start.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; core_reset=1 while reset is low, 0 on the first cycle after release. s_ready, core_in_ready, core_is_last, busy, done, err = 0. core_in=0, core_byte_num=0, byte count=0.
- All outputs are registered. The state machine is IDLE -> CLR -> COLLECT <-> SEND -> (PAD) -> WAIT -> IDLE.
- IDLE: s_ready=0. When s_valid=1: go to CLR, set busy=1, clear err. The byte is not consumed yet.
- CLR: core_reset=1 for exactly one cycle, then COLLECT.
- COLLECT: s_ready=1. Each accepted byte is placed big-endian: byte k of the word goes to bits [31-8k -: 8]; unused bytes are 0. The count increments.
  - After the 4th byte, or on any byte with s_last=1, drop s_ready from the next cycle and go to SEND. Record last_flag=s_last.
- SEND: core_in_ready=1 and core_in=packed word.
  - If last_flag and count<4: core_is_last=1, core_byte_num=count (1..3).
  - Otherwise core_is_last=0 and core_byte_num=0.
  - The word is consumed at a posedge with core_buffer_full=0. While core_buffer_full=1, hold every core_* output stable.
  - On consume:
    - not last: clear the word, count=0, go to COLLECT.
    - last with count<4: go to WAIT.
    - last with count==4: go to PAD.
- PAD: core_in=0, core_in_ready=1, core_is_last=1, core_byte_num=0. Same buffer_full stall rule. On consume go to WAIT.
- WAIT: core_in_ready=0, core_is_last=0. The timer starts at 0 on entry.
  - core_out_ready=1: done=1 for one cycle, busy=0, go to IDLE.
  - Timer reaches WAIT_LIMIT: err=1, busy=0, go to IDLE.
- s_ready is 0 in every state except COLLECT. The source must hold s_data/s_last stable until accepted.
- Zero-length messages are not supported (s_last always accompanies a byte).
- Reset mid-operation: abort immediately to reset values. The partial word is discarded and the core is held in reset.
- core_out_ready is ignored outside WAIT (a stale digest from the prior message is cleared by CLR).

Decomposition:
- Package keccak_feed_pkg: state enum (IDLE, CLR, COLLECT, SEND, PAD, WAIT), WORD_W=32, BYTE_W=8, DIGEST_W=512.
- One sub-module, keccak_byte_packer: holds the 32-bit word shift/insert register and the 3-bit count, with load, clear and full/last outputs. The FSM, the stall logic and the timer stay in the top.

Test Plan:
- "Hello, world!" (13 bytes, s_last on '!'), no stalls -> words 0x48656C6C, 0x6F2C2077, 0x6F726C64, then 0x21000000 with is_last=1, byte_num=1. One core_reset pulse precedes the first word. done pulses once.
- "Hello, world" (12 bytes) -> 3 words with is_last=0, then PAD word 0x00000000 with is_last=1, byte_num=0. 4 in_ready cycles total.
- "The quick brown fox jumps over the lazy dog" with a keccak instance; assert core_buffer_full for 5 cycles mid-message -> core_in is held stable throughout and no word is duplicated or lost. out matches the software Keccak model.
- Back-to-back messages "1234567890" then "password123" -> second message starts with a fresh core_reset pulse. Second word stream ends with "123" plus 0x00, byte_num=3. Both digests match the model.
- Hold core_out_ready=0 in WAIT -> err=1 exactly WAIT_LIMIT cycles after entering WAIT, busy=0, no done pulse. The next message clears err.
- Drive reset=0 during SEND with buffer_full=1 -> next cycle core_in_ready=0, core_reset=1, state=IDLE. After release a full message completes correctly.
